// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: word defaults, inverse-butterfly FSM encoding,
// MAC op codes and the output reduction (saturate when INV_BUTTERFLY_SAT_EN is defined, else wrap).
package fft_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int FRACTION_DEF  = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SUM  = 3'd1;
  localparam logic [2:0] ST_MUL0 = 3'd2;
  localparam logic [2:0] ST_MUL1 = 3'd3;
  localparam logic [2:0] ST_MUL2 = 3'd4;
  localparam logic [2:0] ST_MUL3 = 3'd5;
  localparam logic [2:0] ST_OUT  = 3'd6;

  typedef enum logic [1:0] {
    MAC_HOLD = 2'd0,
    MAC_LOAD = 2'd1,
    MAC_ADD  = 2'd2,
    MAC_SUB  = 2'd3
  } mac_op_t;

  // Reduces a wide signed value to w bits; caller keeps the low w bits of the result.
  function automatic logic signed [63:0] reduce_word(input logic signed [63:0] v, input int w);
`ifdef INV_BUTTERFLY_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/inv_bf_mac.sv
// Signed WORD_SIZE x WORD_SIZE multiplier feeding a load/add/subtract accumulator.
// acc_next is the value the accumulator takes at the coming edge.
module inv_bf_mac
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  mac_op_t                       op,
  input  logic signed [WORD_SIZE-1:0]   op_a,
  input  logic signed [WORD_SIZE-1:0]   op_b,
  output logic signed [2*WORD_SIZE:0]   acc_next
);

  logic signed [2*WORD_SIZE-1:0] prod;
  logic signed [2*WORD_SIZE:0]   prod_ext;
  logic signed [2*WORD_SIZE:0]   acc;

  assign prod     = $signed({{WORD_SIZE{op_a[WORD_SIZE-1]}}, op_a}) *
                    $signed({{WORD_SIZE{op_b[WORD_SIZE-1]}}, op_b});
  assign prod_ext = {prod[2*WORD_SIZE-1], prod};

  always_comb begin
    acc_next = acc;
    case (op)
      MAC_LOAD: acc_next = prod_ext;
      MAC_ADD:  acc_next = acc + prod_ext;
      MAC_SUB:  acc_next = acc - prod_ext;
      default:  acc_next = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= acc_next;
  end

endmodule

// File: rtl/inv_butterfly2.sv
// Radix-2 inverse butterfly: a = (X0+X1)/2, b = ((X0-X1)/2)*conj(W) on one shared multiplier.
// Product saturation is enabled by defining INV_BUTTERFLY_SAT_EN; otherwise it wraps.
module inv_butterfly2
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int FRACTION  = FRACTION_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD_SIZE-1:0] i_in0_re,
  input  logic [WORD_SIZE-1:0] i_in0_im,
  input  logic [WORD_SIZE-1:0] i_in1_re,
  input  logic [WORD_SIZE-1:0] i_in1_im,
  input  logic [WORD_SIZE-1:0] i_twiddle_re,
  input  logic [WORD_SIZE-1:0] i_twiddle_im,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_out0_re,
  output logic [WORD_SIZE-1:0] o_out0_im,
  output logic [WORD_SIZE-1:0] o_out1_re,
  output logic [WORD_SIZE-1:0] o_out1_im
);

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // Upstream: o_ready is high only in IDLE. Downstream: o_valid and outputs hold until i_ready.

  localparam int ACC_W = 2 * WORD_SIZE + 1;

  logic [2:0] state;
  logic [2:0] state_next;

  logic signed [WORD_SIZE-1:0] x0_re, x0_im, x1_re, x1_im, w_re, w_im;
  logic signed [WORD_SIZE-1:0] d_re, d_im;
  logic signed [WORD_SIZE:0]   sum_re, sum_im, dif_re, dif_im;

  mac_op_t                     mac_op;
  logic signed [WORD_SIZE-1:0] mac_a, mac_b;
  logic signed [ACC_W-1:0]     acc_next;
  logic signed [ACC_W-1:0]     re_acc;
  logic signed [ACC_W-1:0]     re_shift, im_shift;

  assign o_ready = (state == ST_IDLE);

  assign sum_re = {x0_re[WORD_SIZE-1], x0_re} + {x1_re[WORD_SIZE-1], x1_re};
  assign sum_im = {x0_im[WORD_SIZE-1], x0_im} + {x1_im[WORD_SIZE-1], x1_im};
  assign dif_re = {x0_re[WORD_SIZE-1], x0_re} - {x1_re[WORD_SIZE-1], x1_re};
  assign dif_im = {x0_im[WORD_SIZE-1], x0_im} - {x1_im[WORD_SIZE-1], x1_im};

  assign re_shift = re_acc >>> FRACTION;
  assign im_shift = acc_next >>> FRACTION;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (i_valid) state_next = ST_SUM;
      ST_SUM:  state_next = ST_MUL0;
      ST_MUL0: state_next = ST_MUL1;
      ST_MUL1: state_next = ST_MUL2;
      ST_MUL2: state_next = ST_MUL3;
      ST_MUL3: state_next = ST_OUT;
      ST_OUT:  if (i_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand schedule: re = dr*wr + di*wi, then im = di*wr - dr*wi.
  always_comb begin
    mac_op = MAC_HOLD;
    mac_a  = '0;
    mac_b  = '0;
    case (state)
      ST_MUL0: begin mac_op = MAC_LOAD; mac_a = d_re; mac_b = w_re; end
      ST_MUL1: begin mac_op = MAC_ADD;  mac_a = d_im; mac_b = w_im; end
      ST_MUL2: begin mac_op = MAC_LOAD; mac_a = d_im; mac_b = w_re; end
      ST_MUL3: begin mac_op = MAC_SUB;  mac_a = d_re; mac_b = w_im; end
      default: begin mac_op = MAC_HOLD; mac_a = '0;   mac_b = '0;   end
    endcase
  end

  inv_bf_mac #(
    .WORD_SIZE (WORD_SIZE)
  ) u_mac (
    .clk      (i_clk),
    .rst      (i_rst),
    .op       (mac_op),
    .op_a     (mac_a),
    .op_b     (mac_b),
    .acc_next (acc_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_valid   <= 1'b0;
      o_out0_re <= '0;
      o_out0_im <= '0;
      o_out1_re <= '0;
      o_out1_im <= '0;
      x0_re     <= '0;
      x0_im     <= '0;
      x1_re     <= '0;
      x1_im     <= '0;
      w_re      <= '0;
      w_im      <= '0;
      d_re      <= '0;
      d_im      <= '0;
      re_acc    <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            x0_re <= i_in0_re;
            x0_im <= i_in0_im;
            x1_re <= i_in1_re;
            x1_im <= i_in1_im;
            w_re  <= i_twiddle_re;
            w_im  <= i_twiddle_im;
          end
        end
        ST_SUM: begin
          o_out0_re <= WORD_SIZE'(sum_re >>> 1);
          o_out0_im <= WORD_SIZE'(sum_im >>> 1);
          d_re      <= WORD_SIZE'(dif_re >>> 1);
          d_im      <= WORD_SIZE'(dif_im >>> 1);
        end
        ST_MUL1: re_acc <= acc_next;
        ST_MUL3: begin
          // The imaginary sum is finished by this edge's subtract, so use acc_next.
          o_out1_re <= WORD_SIZE'(reduce_word(64'(re_shift), WORD_SIZE));
          o_out1_im <= WORD_SIZE'(reduce_word(64'(im_shift), WORD_SIZE));
          o_valid   <= 1'b1;
        end
        ST_OUT: if (i_ready) o_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_butterfly2.sv
// Self-checking bench for inv_butterfly2 (build with or without INV_BUTTERFLY_SAT_EN).
module tb_inv_butterfly2;

  localparam int W  = 16;
  localparam int FR = 8;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_twiddle_re, i_twiddle_im;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;

  int checks   = 0;
  int failures = 0;

  inv_butterfly2 #(.WORD_SIZE(W), .FRACTION(FR)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_in0_re     (i_in0_re),
    .i_in0_im     (i_in0_im),
    .i_in1_re     (i_in1_re),
    .i_in1_im     (i_in1_im),
    .i_twiddle_re (i_twiddle_re),
    .i_twiddle_im (i_twiddle_im),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_out0_re    (o_out0_re),
    .o_out0_im    (o_out0_im),
    .o_out1_re    (o_out1_re),
    .o_out1_im    (o_out1_im)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [W-1:0] fit(input longint v);
    longint t;
    t = v;
`ifdef INV_BUTTERFLY_SAT_EN
    if (t > 32767) t = 32767;
    else if (t < -32768) t = -32768;
`endif
    return 16'(t);
  endfunction

  function automatic void model(input logic [W-1:0] a0r, a0i, a1r, a1i, twr, twi,
                                output logic [W-1:0] e0r, e0i, e1r, e1i);
    longint dr, di;
    e0r = 16'((sx(a0r) + sx(a1r)) >>> 1);
    e0i = 16'((sx(a0i) + sx(a1i)) >>> 1);
    dr  = (sx(a0r) - sx(a1r)) >>> 1;
    di  = (sx(a0i) - sx(a1i)) >>> 1;
    e1r = fit((dr * sx(twr) + di * sx(twi)) >>> FR);
    e1i = fit((di * sx(twr) - dr * sx(twi)) >>> FR);
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    i_valid      = 1'b0;
    i_in0_re     = 16'($urandom);
    i_in0_im     = 16'($urandom);
    i_in1_re     = 16'($urandom);
    i_in1_im     = 16'($urandom);
    i_twiddle_re = 16'($urandom);
    i_twiddle_im = 16'($urandom);
  endtask

  task automatic present(input logic [W-1:0] a0r, a0i, a1r, a1i, twr, twi);
    i_in0_re = a0r; i_in0_im = a0i; i_in1_re = a1r; i_in1_im = a1i;
    i_twiddle_re = twr; i_twiddle_im = twi;
    i_valid = 1'b1;
  endtask

  // Waits for o_ready, accepts one pair, waits for o_valid (bounded), captures, then drains.
  task automatic run_txn(input logic [W-1:0] a0r, a0i, a1r, a1i, twr, twi,
                         output logic [W-1:0] r0r, r0i, r1r, r1i,
                         output int lat, output bit drain_ok);
    int guard;
    guard = 0;
    while (!o_ready && guard < 20) begin @(posedge i_clk); #1; guard++; end
    i_ready = 1'b0;
    present(a0r, a0i, a1r, a1i, twr, twi);
    @(posedge i_clk); #1;
    idle_inputs();
    lat = 0;
    while (!o_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
    r0r = o_out0_re; r0i = o_out0_im; r1r = o_out1_re; r1i = o_out1_im;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    drain_ok = !o_valid && o_ready;
    i_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit stray;
    i_rst = 1'b1; i_ready = 1'b0; idle_inputs();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", o_ready); end
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++;
    if ({o_out0_re, o_out0_im, o_out1_re, o_out1_im} !== 64'd0) begin
      failures++;
      $display("FAIL reset_outs got=%h %h %h %h want=0", o_out0_re, o_out0_im, o_out1_re, o_out1_im);
    end
    // reset and a handshake on the same edge: reset must win
    present(16'h0300, 0, 16'h0100, 0, 16'h0100, 0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; idle_inputs();
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_vs_accept_ready got=%b want=1", o_ready); end
    stray = 1'b0;
    repeat (8) begin @(posedge i_clk); #1; if (o_valid) stray = 1'b1; end
    checks++;
    if (stray !== 1'b0) begin failures++; $display("FAIL reset_vs_accept_valid got=%b want=0", stray); end
  endtask

  task automatic test_real_twiddle();
    logic [W-1:0] r0r, r0i, r1r, r1i; int lat; bit dok;
    run_txn(16'h0300, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, r0r, r0i, r1r, r1i, lat, dok);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL real_latency got=%0d want=5", lat); end
    checks++;
    if ({r0r, r0i} !== {16'h0200, 16'h0000}) begin failures++; $display("FAIL real_out0 got=%h,%h want=0200,0000", r0r, r0i); end
    checks++;
    if ({r1r, r1i} !== {16'h0100, 16'h0000}) begin failures++; $display("FAIL real_out1 got=%h,%h want=0100,0000", r1r, r1i); end
    checks++;
    if (dok !== 1'b1) begin failures++; $display("FAIL real_drain got=%b want=1", dok); end
  endtask

  task automatic test_imag_twiddle();
    logic [W-1:0] r0r, r0i, r1r, r1i; int lat; bit dok;
    run_txn(16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'h0000, 16'h0100, r0r, r0i, r1r, r1i, lat, dok);
    checks++;
    if ({r0r, r0i} !== {16'h0100, 16'h0000}) begin failures++; $display("FAIL imag_out0 got=%h,%h want=0100,0000", r0r, r0i); end
    checks++;
    if ({r1r, r1i} !== {16'h0100, 16'h0000}) begin failures++; $display("FAIL imag_out1 got=%h,%h want=0100,0000", r1r, r1i); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] r0r, r0i, r1r, r1i, want_im; int lat; bit dok;
`ifdef INV_BUTTERFLY_SAT_EN
    want_im = 16'h7FFF;
`else
    want_im = 16'hFFFE;
`endif
    run_txn(16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001, 16'h0100, 16'hFF00, r0r, r0i, r1r, r1i, lat, dok);
    checks++;
    if ({r0r, r0i} !== 32'd0) begin failures++; $display("FAIL ovf_out0 got=%h,%h want=0,0", r0r, r0i); end
    checks++;
    if (r1r !== 16'h0000) begin failures++; $display("FAIL ovf_out1_re got=%h want=0000", r1r); end
    checks++;
    if (r1i !== want_im) begin failures++; $display("FAIL ovf_out1_im got=%h want=%h", r1i, want_im); end
  endtask

  task automatic test_random();
    logic [W-1:0] v[6]; logic [W-1:0] r0r, r0i, r1r, r1i, e0r, e0i, e1r, e1i; int lat; bit dok;
    int bad;
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 6; k++) v[k] = 16'($urandom);
      model(v[0], v[1], v[2], v[3], v[4], v[5], e0r, e0i, e1r, e1i);
      run_txn(v[0], v[1], v[2], v[3], v[4], v[5], r0r, r0i, r1r, r1i, lat, dok);
      checks++;
      if ({r0r, r0i, r1r, r1i} !== {e0r, e0i, e1r, e1i} || lat != 5 || !dok) begin
        failures++;
        if (bad < 5) $display("FAIL random_vec n=%0d got=%h %h %h %h lat=%0d want=%h %h %h %h lat=5",
                              n, r0r, r0i, r1r, r1i, lat, e0r, e0i, e1r, e1i);
        bad++;
      end
    end
  endtask

  task automatic test_round_trip();
    longint ar, ai, br, bi, bwr, bwi, wr, wi;
    logic [W-1:0] x0r, x0i, x1r, x1i, r0r, r0i, r1r, r1i, e0r, e0i, e1r, e1i; int lat; bit dok;
    int bad;
    bad = 0;
    wr = 181; wi = -181;
    for (int n = 0; n < 1000; n++) begin
      ar = longint'($urandom_range(4094)) - 2047; ai = longint'($urandom_range(4094)) - 2047;
      br = longint'($urandom_range(4094)) - 2047; bi = longint'($urandom_range(4094)) - 2047;
      bwr = (br * wr - bi * wi) >>> FR;
      bwi = (br * wi + bi * wr) >>> FR;
      x0r = 16'(ar + bwr); x0i = 16'(ai + bwi);
      x1r = 16'(ar - bwr); x1i = 16'(ai - bwi);
      model(x0r, x0i, x1r, x1i, 16'h00B5, 16'hFF4B, e0r, e0i, e1r, e1i);
      run_txn(x0r, x0i, x1r, x1i, 16'h00B5, 16'hFF4B, r0r, r0i, r1r, r1i, lat, dok);
      checks++;
      if ({r0r, r0i, r1r, r1i} !== {e0r, e0i, e1r, e1i}) begin
        failures++;
        if (bad < 5) $display("FAIL rt_model n=%0d got=%h %h %h %h want=%h %h %h %h",
                              n, r0r, r0i, r1r, r1i, e0r, e0i, e1r, e1i);
        bad++;
      end
      checks++;
      if (sx(r0r) - ar > 2 || ar - sx(r0r) > 2 || sx(r0i) - ai > 2 || ai - sx(r0i) > 2 ||
          sx(r1r) - br > 2 || br - sx(r1r) > 2 || sx(r1i) - bi > 2 || bi - sx(r1i) > 2) begin
        failures++;
        if (bad < 5) $display("FAIL rt_tolerance n=%0d got=%0d %0d %0d %0d want=%0d %0d %0d %0d (+-2)",
                              n, sx(r0r), sx(r0i), sx(r1r), sx(r1i), ar, ai, br, bi);
        bad++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e0r, e0i, e1r, e1i, s0r, s0i, s1r, s1i; int guard; bit unstable, stray;
    model(16'h1234, 16'hF00D, 16'h0F0F, 16'h2222, 16'h00B5, 16'h0040, e0r, e0i, e1r, e1i);
    i_ready = 1'b0;
    present(16'h1234, 16'hF00D, 16'h0F0F, 16'h2222, 16'h00B5, 16'h0040);
    @(posedge i_clk); #1;
    idle_inputs();
    guard = 0;
    while (!o_valid && guard < 20) begin @(posedge i_clk); #1; guard++; end
    s0r = o_out0_re; s0i = o_out0_im; s1r = o_out1_re; s1i = o_out1_im;
    checks++;
    if ({s0r, s0i, s1r, s1i} !== {e0r, e0i, e1r, e1i} || guard != 5) begin
      failures++;
      $display("FAIL bp_result got=%h %h %h %h lat=%0d want=%h %h %h %h lat=5", s0r, s0i, s1r, s1i, guard, e0r, e0i, e1r, e1i);
    end
    unstable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) present(16'h0300, 0, 16'h0100, 0, 16'h0100, 0);
      @(posedge i_clk); #1;
      if (c == 3) idle_inputs();
      if (o_valid !== 1'b1 || o_ready !== 1'b0 ||
          {o_out0_re, o_out0_im, o_out1_re, o_out1_im} !== {s0r, s0i, s1r, s1i}) unstable = 1'b1;
    end
    checks++;
    if (unstable !== 1'b0) begin failures++; $display("FAIL bp_hold got=unstable want=stable"); end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got=valid%b ready%b want=valid0 ready1", o_valid, o_ready);
    end
    stray = 1'b0;
    repeat (8) begin @(posedge i_clk); #1; if (o_valid) stray = 1'b1; end
    checks++;
    if (stray !== 1'b0) begin failures++; $display("FAIL bp_pulse_ignored got=%b want=0", stray); end
  endtask

  task automatic test_reset_mid();
    bit stray;
    i_ready = 1'b1;
    present(16'h0300, 16'h0011, 16'h0100, 16'h0022, 16'h0100, 16'h0033);
    @(posedge i_clk); #1;
    idle_inputs();
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_ctrl got=valid%b ready%b want=valid0 ready1", o_valid, o_ready);
    end
    checks++;
    if ({o_out0_re, o_out0_im, o_out1_re, o_out1_im} !== 64'd0) begin
      failures++; $display("FAIL midrst_outs got=%h %h %h %h want=0", o_out0_re, o_out0_im, o_out1_re, o_out1_im);
    end
    stray = 1'b0;
    repeat (10) begin @(posedge i_clk); #1; if (o_valid) stray = 1'b1; end
    checks++;
    if (stray !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%b want=0", stray); end
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v[6]; logic [W-1:0] e0r, e0i, e1r, e1i; int guard;
    i_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 6; k++) v[k] = 16'($urandom);
      model(v[0], v[1], v[2], v[3], v[4], v[5], e0r, e0i, e1r, e1i);
      present(v[0], v[1], v[2], v[3], v[4], v[5]);
      @(posedge i_clk); #1;
      idle_inputs();
      guard = 0;
      while (!o_valid && guard < 20) begin @(posedge i_clk); #1; guard++; end
      checks++;
      if ({o_out0_re, o_out0_im, o_out1_re, o_out1_im} !== {e0r, e0i, e1r, e1i} || guard != 5) begin
        failures++;
        $display("FAIL b2b_result n=%0d got=%h %h %h %h lat=%0d want=%h %h %h %h lat=5",
                 n, o_out0_re, o_out0_im, o_out1_re, o_out1_im, guard, e0r, e0i, e1r, e1i);
      end
      @(posedge i_clk); #1;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_return n=%0d got=valid%b ready%b want=valid0 ready1", n, o_valid, o_ready);
      end
    end
    i_ready = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_real_twiddle();
    test_imag_twiddle();
    test_overflow();
    test_random();
    test_round_trip();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
